// File: rtl/arm_mem_port_arbiter_if.sv
// Bus bundle between the arbiter, the core's fetch/data requesters and the memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface arm_mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              halted;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_en;
    logic [DATA_W-1:0] mem_data_out;
    logic              busy;

    modport slave (
        input  halted, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_addr, mem_data_in, mem_write_en, busy
    );

    modport master (
        output halted, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_addr, mem_data_in, mem_write_en, busy
    );
endinterface

// File: rtl/arm_mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction
// at a time, round-robin on contention; fetch is locked out while the core is halted.
module arm_mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    arm_mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT, S_RESP} state_t;
    typedef enum logic {PORT_IF, PORT_D} port_t;

    state_t            state;
    port_t             last_served;
    port_t             owner;
    logic              lat_we;
    logic [CNT_W-1:0]  cnt;

    logic              if_el;
    logic              d_el;
    logic              pick_d;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    always_comb begin
        if_el     = bus.if_req & ~bus.halted;
        d_el      = bus.d_req;
        pick_d    = d_el & (~if_el | (last_served == PORT_IF));
        addr_sel  = pick_d ? bus.d_addr : bus.if_addr;
        wdata_sel = pick_d ? bus.d_wdata : '0;
    end

    // WAIT always lasts MEM_LATENCY cycles; data is captured on its final edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= S_IDLE;
            last_served      <= PORT_IF;
            owner            <= PORT_IF;
            lat_we           <= 1'b0;
            cnt              <= '0;
            bus.if_gnt       <= 1'b0;
            bus.if_rvalid    <= 1'b0;
            bus.if_rdata     <= '0;
            bus.d_gnt        <= 1'b0;
            bus.d_rvalid     <= 1'b0;
            bus.d_rdata      <= '0;
            bus.mem_req      <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_data_in  <= '0;
            bus.mem_write_en <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.if_gnt       <= 1'b0;
            bus.d_gnt        <= 1'b0;
            bus.if_rvalid    <= 1'b0;
            bus.d_rvalid     <= 1'b0;
            bus.mem_req      <= 1'b0;
            bus.mem_write_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (if_el | d_el) begin
                        owner            <= pick_d ? PORT_D : PORT_IF;
                        last_served      <= pick_d ? PORT_D : PORT_IF;
                        lat_we           <= pick_d & bus.d_we;
                        bus.mem_addr     <= addr_sel;
                        bus.mem_data_in  <= wdata_sel;
                        bus.mem_write_en <= pick_d & bus.d_we;
                        bus.mem_req      <= 1'b1;
                        bus.if_gnt       <= ~pick_d;
                        bus.d_gnt        <= pick_d;
                        bus.busy         <= 1'b1;
                        state            <= S_XFER;
                    end
                end
                S_XFER: begin
                    cnt   <= CNT_W'(MEM_LATENCY - 1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        if (owner == PORT_IF) begin
                            bus.if_rdata  <= bus.mem_data_out;
                            bus.if_rvalid <= 1'b1;
                        end else begin
                            bus.d_rdata  <= lat_we ? '0 : bus.mem_data_out;
                            bus.d_rvalid <= 1'b1;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arm_mem_port_arbiter.sv
// Drives two arbiters (MEM_LATENCY 1 and 3) with shared directed stimulus and checks
// every cycle against a transaction-level timing model, plus hand-computed expectations.
module tb_arm_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halted = 1'b0, if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    int          cyc = 0;
    int          base = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arm_mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) u_bus1 ();
    arm_mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) u_bus3 ();

    arm_mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(u_bus1.slave));
    arm_mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(u_bus3.slave));

    assign u_bus1.halted = halted;   assign u_bus3.halted = halted;
    assign u_bus1.if_req = if_req;   assign u_bus3.if_req = if_req;
    assign u_bus1.if_addr = if_addr; assign u_bus3.if_addr = if_addr;
    assign u_bus1.d_req = d_req;     assign u_bus3.d_req = d_req;
    assign u_bus1.d_we = d_we;       assign u_bus3.d_we = d_we;
    assign u_bus1.d_addr = d_addr;   assign u_bus3.d_addr = d_addr;
    assign u_bus1.d_wdata = d_wdata; assign u_bus3.d_wdata = d_wdata;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h10) ? 32'hE3A000BB : ((a ^ 32'h5A5A0000) + 32'h1);
    endfunction

    // Memory: read data valid only in the cycle exactly L cycles after the mem_req cycle.
    logic [31:0] m_addr0 = '0, m_addr1 = '0;
    int          m_cnt0 = 0, m_cnt1 = 0;
    always @(posedge clk) begin
        if (u_bus1.mem_req) begin m_addr0 <= u_bus1.mem_addr; m_cnt0 <= 1; end
        else if (m_cnt0 != 0) m_cnt0 <= m_cnt0 - 1;
        if (u_bus3.mem_req) begin m_addr1 <= u_bus3.mem_addr; m_cnt1 <= 3; end
        else if (m_cnt1 != 0) m_cnt1 <= m_cnt1 - 1;
    end
    assign u_bus1.mem_data_out = (m_cnt0 == 1) ? memf(m_addr0) : 32'hBAD0BAD0;
    assign u_bus3.mem_data_out = (m_cnt1 == 1) ? memf(m_addr1) : 32'hBAD0BAD0;

    typedef struct packed {
        logic        if_gnt;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        d_gnt;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        mem_req;
        logic [31:0] mem_addr;
        logic [31:0] mem_data_in;
        logic        mem_write_en;
        logic        busy;
    } obs_t;

    obs_t obs [2];
    assign obs[0] = {u_bus1.if_gnt, u_bus1.if_rvalid, u_bus1.if_rdata, u_bus1.d_gnt,
                     u_bus1.d_rvalid, u_bus1.d_rdata, u_bus1.mem_req, u_bus1.mem_addr,
                     u_bus1.mem_data_in, u_bus1.mem_write_en, u_bus1.busy};
    assign obs[1] = {u_bus3.if_gnt, u_bus3.if_rvalid, u_bus3.if_rdata, u_bus3.d_gnt,
                     u_bus3.d_rvalid, u_bus3.d_rdata, u_bus3.mem_req, u_bus3.mem_addr,
                     u_bus3.mem_data_in, u_bus3.mem_write_en, u_bus3.busy};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, " if_gnt"}, a.if_gnt, e.if_gnt);
        chk({tag, " if_rvalid"}, a.if_rvalid, e.if_rvalid);
        chk({tag, " if_rdata"}, a.if_rdata, e.if_rdata);
        chk({tag, " d_gnt"}, a.d_gnt, e.d_gnt);
        chk({tag, " d_rvalid"}, a.d_rvalid, e.d_rvalid);
        chk({tag, " d_rdata"}, a.d_rdata, e.d_rdata);
        chk({tag, " mem_req"}, a.mem_req, e.mem_req);
        chk({tag, " mem_addr"}, a.mem_addr, e.mem_addr);
        chk({tag, " mem_data_in"}, a.mem_data_in, e.mem_data_in);
        chk({tag, " mem_write_en"}, a.mem_write_en, e.mem_write_en);
        chk({tag, " busy"}, a.busy, e.busy);
    endtask

    // Transaction model: a win in cycle s means gnt at s+1, rvalid at s+2+L, next win at s+3+L.
    bit          act [2] = '{0, 0};
    bit          last_d [2] = '{0, 0};
    bit          twin_d [2], twe [2];
    int          ts [2], free_at [2] = '{0, 0};
    logic [31:0] taddr [2], twd [2];
    logic [31:0] h_addr [2] = '{0, 0}, h_wd [2] = '{0, 0};
    logic [31:0] h_ir [2] = '{0, 0}, h_dr [2] = '{0, 0};

    task automatic model_step(input int i);
        int   lat;
        int   c;
        obs_t e;
        bit   ie, de, wd;
        lat = (i == 0) ? 1 : 3;
        c   = cyc;
        e   = '0;
        if (act[i]) begin
            if (c == ts[i] + 1) begin
                h_addr[i]      = taddr[i];
                h_wd[i]        = twd[i];
                e.mem_req      = 1'b1;
                e.mem_write_en = twe[i];
                e.if_gnt       = ~twin_d[i];
                e.d_gnt        = twin_d[i];
            end
            e.busy = (c >= ts[i] + 1) && (c <= ts[i] + 2 + lat);
            if (c == ts[i] + 2 + lat) begin
                if (twin_d[i]) begin h_dr[i] = twe[i] ? 32'h0 : memf(taddr[i]); e.d_rvalid = 1'b1; end
                else begin h_ir[i] = memf(taddr[i]); e.if_rvalid = 1'b1; end
                act[i] = 1'b0;
            end
        end
        e.mem_addr    = h_addr[i];
        e.mem_data_in = h_wd[i];
        e.if_rdata    = h_ir[i];
        e.d_rdata     = h_dr[i];
        if (c >= 1) cmp_obs((i == 0) ? "model L1" : "model L3", obs[i], e);
        if (!rst) begin
            act[i] = 1'b0; last_d[i] = 1'b0; free_at[i] = c + 1;
            h_addr[i] = '0; h_wd[i] = '0; h_ir[i] = '0; h_dr[i] = '0;
        end else if (!act[i] && c >= free_at[i]) begin
            ie = if_req & ~halted;
            de = d_req;
            if (ie | de) begin
                wd         = (ie & de) ? ~last_d[i] : de;
                last_d[i]  = wd;
                twin_d[i]  = wd;
                twe[i]     = wd & d_we;
                taddr[i]   = wd ? d_addr : if_addr;
                twd[i]     = wd ? d_wdata : 32'h0;
                ts[i]      = c;
                act[i]     = 1'b1;
                free_at[i] = c + 3 + lat;
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic goto(input int n);
        while (cyc < base + n) begin @(posedge clk); #1; end
    endtask

    task automatic neg(input int n);
        goto(n);
        @(negedge clk);
    endtask

    typedef struct {
        int          n;
        bit          ir, h, dr, dw;
        logic [31:0] ia, da, wd;
    } row_t;
    row_t rows [5];
    int   gcount;

    initial begin
        rows[0] = '{6, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h204, 32'h11112222};
        rows[1] = '{2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h208, 32'h0};
        rows[2] = '{5, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4C, 32'h208, 32'h0};
        rows[3] = '{9, 1'b1, 1'b0, 1'b1, 1'b0, 32'h48, 32'h20C, 32'h0};
        rows[4] = '{4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h48, 32'h20C, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        base = cyc;
        chk("reset busy", obs[0].busy, 1'b0);
        chk("reset mem_addr", obs[1].mem_addr, 32'h0);

        // Single fetch; L=3 instance also gives gnt@1, rvalid@5, busy 1..5.
        if_req = 1'b1; if_addr = 32'h10;
        for (int k = 1; k <= 6; k++) begin
            if (k == 1) begin goto(1); if_req = 1'b0; end
            neg(k);
            if (k == 1) begin
                chk("t1 L1 if_gnt", obs[0].if_gnt, 1'b1);
                chk("t1 L1 mem_req", obs[0].mem_req, 1'b1);
                chk("t1 L1 mem_addr", obs[0].mem_addr, 32'h10);
                chk("t6 L3 if_gnt", obs[1].if_gnt, 1'b1);
            end
            if (k == 3) begin
                chk("t1 L1 if_rvalid", obs[0].if_rvalid, 1'b1);
                chk("t1 L1 if_rdata", obs[0].if_rdata, 32'hE3A000BB);
                chk("t6 L3 early rvalid", obs[1].if_rvalid, 1'b0);
            end
            if (k == 5) begin
                chk("t6 L3 if_rvalid", obs[1].if_rvalid, 1'b1);
                chk("t6 L3 if_rdata", obs[1].if_rdata, 32'hE3A000BB);
            end
            chk("t6 L3 busy", obs[1].busy, (k <= 5) ? 1'b1 : 1'b0);
        end

        // Contention: D first after an IF win, then strict alternation.
        goto(8); base = cyc;
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        for (int k = 1; k <= 9; k++) begin
            neg(k);
            if (k == 1) begin
                chk("t2 L1 d_gnt first", obs[0].d_gnt, 1'b1);
                chk("t2 L1 if_gnt first", obs[0].if_gnt, 1'b0);
            end
            if (k == 5) chk("t2 L1 if_gnt second", obs[0].if_gnt, 1'b1);
            if (k == 9) chk("t2 L1 d_gnt third", obs[0].d_gnt, 1'b1);
            if (k == 7) chk("t2 L3 if_gnt second", obs[1].if_gnt, 1'b1);
        end
        goto(10); if_req = 1'b0; d_req = 1'b0;

        // Store.
        goto(16); base = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        goto(1); d_req = 1'b0;
        neg(1);
        chk("t3 mem_write_en", obs[0].mem_write_en, 1'b1);
        chk("t3 mem_addr", obs[0].mem_addr, 32'h200);
        chk("t3 mem_data_in", obs[0].mem_data_in, 32'hDEADBEEF);
        neg(2);
        chk("t3 mem_write_en off", obs[0].mem_write_en, 1'b0);
        neg(3);
        chk("t3 d_rvalid", obs[0].d_rvalid, 1'b1);
        chk("t3 d_rdata", obs[0].d_rdata, 32'h0);
        chk("t3 if_rvalid", obs[0].if_rvalid, 1'b0);

        // Halted: fetch locked out, data served.
        goto(8); base = cyc;
        halted = 1'b1; if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        gcount = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) begin goto(1); d_req = 1'b0; end
            neg(k);
            gcount += int'(obs[0].if_gnt) + int'(obs[1].if_gnt);
            if (k == 3) begin
                chk("t4 d_rvalid", obs[0].d_rvalid, 1'b1);
                chk("t4 d_rdata", obs[0].d_rdata, memf(32'h300));
            end
        end
        chk("t4 if_gnt count", gcount, 0);
        goto(21); if_req = 1'b0; halted = 1'b0;

        // Reset during L=3 WAIT, then a fresh fetch.
        goto(25); base = cyc;
        if_req = 1'b1; if_addr = 32'h20;
        goto(1); if_req = 1'b0;
        goto(3); rst = 1'b0;
        goto(4); rst = 1'b1; base = cyc;
        if_req = 1'b1; if_addr = 32'h24;
        for (int k = 0; k <= 6; k++) begin
            if (k == 1) begin goto(1); if_req = 1'b0; end
            neg(k);
            if (k == 0) begin
                chk("t5 busy after rst", obs[1].busy, 1'b0);
                chk("t5 if_rdata after rst", obs[1].if_rdata, 32'h0);
                chk("t5 mem_addr after rst", obs[1].mem_addr, 32'h0);
            end
            if (k <= 4) chk("t5 no rvalid", obs[1].if_rvalid, 1'b0);
            if (k == 1) chk("t5 if_gnt", obs[1].if_gnt, 1'b1);
            if (k == 5) begin
                chk("t5 if_rvalid", obs[1].if_rvalid, 1'b1);
                chk("t5 if_rdata", obs[1].if_rdata, memf(32'h24));
            end
        end

        // Mixed traffic checked by the model alone.
        goto(8); base = 0;
        for (int r = 0; r < 5; r++) begin
            if_req = rows[r].ir; halted = rows[r].h; d_req = rows[r].dr; d_we = rows[r].dw;
            if_addr = rows[r].ia; d_addr = rows[r].da; d_wdata = rows[r].wd;
            base = cyc;
            goto(rows[r].n);
        end
        base = cyc;
        goto(12);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
